// File: rtl/router_nch_fifo.sv
// Purpose : byte-serial packet router steering [hdr][payload x len][parity] into NUM_CH FWFT FIFOs.
// Latency : header accepted at cycle T -> vld_chan of its channel high at T+1; err 1 cycle after the bad byte.
// Backpressure: suspend_data_in (from registered state only) holds the sender while the target FIFO is full.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   data, packet_valid     input byte and its qualifier (byte taken iff packet_valid && !suspend_data_in)
//   err                    1-cycle pulse: parity mismatch or illegal address
//   suspend_data_in        1 = byte not taken this cycle, sender holds data
//   channel_data           FIFO head of channel i at [i*DATA_W +: DATA_W], zero while empty
//   vld_chan               channel i FIFO non-empty
//   read_enb               pop channel i head this cycle (ignored when empty)

// Generic first-word-fall-through FIFO used once per output channel.
// Push is dropped when full and pop is dropped when empty, so callers can drive them loosely.
module router_nch_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == FULL_CNT);
  assign head_vld = (count != '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && head_vld;
  // Gate the head so an empty or freshly reset FIFO shows zero instead of stale storage.
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the occupancy counter decides what is visible.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module router_nch_fifo #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data,
  input  logic                     packet_valid,
  output logic                     err,
  output logic                     suspend_data_in,
  output logic [NUM_CH*DATA_W-1:0] channel_data,
  output logic [NUM_CH-1:0]        vld_chan,
  input  logic [NUM_CH-1:0]        read_enb
);
  localparam int LEN_W = DATA_W - ADDR_W;
  // One extra bit: illegal packets count len payload bytes plus the parity byte.
  localparam int REM_W = LEN_W + 1;
  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   dst;
  logic [DATA_W-1:0]   acc;
  logic [REM_W-1:0]    remain;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic                hdr_legal;
  logic                accept;
  logic                dst_full;
  logic [NUM_CH-1:0]   fifo_full;
  logic [NUM_CH-1:0]   fifo_push;

  assign hdr_addr  = data[ADDR_W-1:0];
  assign hdr_len   = data[DATA_W-1:ADDR_W];
  assign hdr_legal = ({1'b0, hdr_addr} < NUM_CH_L);
  assign accept    = packet_valid && !suspend_data_in;

  always_comb begin
    dst_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dst == ADDR_W'(i)) dst_full = fifo_full[i];
    end
  end

  // In IDLE the destination is not known until the header arrives, and suspend
  // must not depend on data, so any full FIFO holds off the next header.
  always_comb begin
    suspend_data_in = 1'b0;
    case (state)
      IDLE:           suspend_data_in = |fifo_full;
      PAYLOAD, PARITY: suspend_data_in = dst_full;
      default:        suspend_data_in = 1'b0;
    endcase
  end

  always_comb begin
    fifo_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept) begin
        if (state == IDLE)
          fifo_push[i] = hdr_legal && (hdr_addr == ADDR_W'(i));
        else if (state == PAYLOAD || state == PARITY)
          fifo_push[i] = (dst == ADDR_W'(i));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dst    <= '0;
      acc    <= '0;
      remain <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            dst <= hdr_addr;
            acc <= data;
            if (hdr_legal) begin
              remain <= {1'b0, hdr_len};
              state  <= (hdr_len == '0) ? PARITY : PAYLOAD;
            end else begin
              remain <= {1'b0, hdr_len} + REM_W'(1);
              err    <= 1'b1;
              state  <= DROP;
            end
          end
          PAYLOAD: begin
            acc    <= acc ^ data;
            remain <= remain - 1'b1;
            if (remain == REM_W'(1)) state <= PARITY;
          end
          PARITY: begin
            err   <= (data != acc);
            state <= IDLE;
          end
          DROP: begin
            remain <= remain - 1'b1;
            if (remain == REM_W'(1)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_nch_fifo_buf #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifo_push[g]),
      .push_dat (data),
      .pop      (read_enb[g]),
      .head_dat (channel_data[g*DATA_W +: DATA_W]),
      .head_vld (vld_chan[g]),
      .full     (fifo_full[g])
    );
  end
endmodule

// File: tb/tb_router_nch_fifo.sv
module tb_router_nch_fifo;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        packet_valid;
  logic        err;
  logic        suspend_data_in;
  logic [23:0] channel_data;
  logic [2:0]  vld_chan;
  logic [2:0]  read_enb;

  router_nch_fifo #(.DATA_W(8), .ADDR_W(2), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .data            (data),
    .packet_valid    (packet_valid),
    .err             (err),
    .suspend_data_in (suspend_data_in),
    .channel_data    (channel_data),
    .vld_chan        (vld_chan),
    .read_enb        (read_enb)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: one byte queue per channel plus packet-level progress.
  logic [7:0] mq [NUM_CH][$];
  bit         in_pkt;
  bit         dropping;
  int         dst;
  int         left;
  logic [7:0] pacc;

  int         gap_pct = 0;
  int         rd_pct  = 0;
  logic [2:0] rd_mask = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_susp();
    bit s = 1'b0;
    if (!in_pkt) begin
      for (int i = 0; i < NUM_CH; i++) if (mq[i].size() == DEPTH) s = 1'b1;
    end else if (!dropping) begin
      s = (mq[dst].size() == DEPTH);
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) mq[i].delete();
    in_pkt = 0; dropping = 0; dst = 0; left = 0; pacc = '0;
  endtask

  task automatic model_byte(input logic [7:0] d, output bit e);
    int a;
    e = 1'b0;
    if (!in_pkt) begin
      a      = int'(d & 8'h03);
      left   = int'(d >> 2) + 1;   // payload bytes + parity byte
      pacc   = d;
      in_pkt = 1;
      if (a < NUM_CH) begin
        mq[a].push_back(d);
        dst = a; dropping = 0;
      end else begin
        dropping = 1; e = 1'b1;
      end
    end else if (dropping) begin
      left--;
      if (left == 0) in_pkt = 0;
    end else begin
      mq[dst].push_back(d);
      if (left == 1) begin
        e = (d != pacc);
        in_pkt = 0;
      end else begin
        pacc = pacc ^ d;
      end
      left--;
    end
  endtask

  task automatic check_outputs();
    chk("suspend", suspend_data_in, exp_susp());
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("vld_chan%0d", i), vld_chan[i], mq[i].size() != 0);
      if (mq[i].size() != 0) chk($sformatf("head%0d", i), channel_data[i*8 +: 8], mq[i][0]);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model, check err after the edge.
  task automatic cycle(input logic pv, input logic [7:0] d, input logic [2:0] re, output bit accepted);
    bit e;
    check_outputs();
    packet_valid = pv; data = d; read_enb = re;
    accepted = pv && !exp_susp();
    for (int i = 0; i < NUM_CH; i++) if (re[i] && mq[i].size() != 0) void'(mq[i].pop_front());
    e = 1'b0;
    if (accepted) model_byte(d, e);
    @(posedge clock); #1;
    chk("err", err, e);
    packet_valid = 1'b0; read_enb = '0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit a = 0;
    int n = 0;
    logic [2:0] re;
    while (!a && n < 500) begin
      re = rd_mask;
      for (int i = 0; i < NUM_CH; i++) if ($urandom_range(99) < rd_pct) re[i] = 1'b1;
      cycle($urandom_range(99) >= gap_pct, d, re, a);
      n++;
    end
    chk("accept_timeout", a, 1);
  endtask

  task automatic send_pkt(input logic [7:0] q[$]);
    foreach (q[k]) send_byte(q[k]);
  endtask

  task automatic make_pkt(input int addr, input int len, input bit corrupt, output logic [7:0] q[$]);
    logic [7:0] b;
    logic [7:0] p;
    q.delete();
    b = 8'((len << 2) | addr);
    q.push_back(b); p = b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(255));
      q.push_back(b); p = p ^ b;
    end
    if (corrupt) p = p ^ 8'($urandom_range(255, 1));
    q.push_back(p);
  endtask

  task automatic drain();
    bit a;
    int n = 0;
    int sz = 1;
    while (sz != 0 && n < 500) begin
      cycle(1'b0, 8'h00, 3'b111, a);
      sz = 0;
      for (int i = 0; i < NUM_CH; i++) sz += mq[i].size();
      n++;
    end
    chk("drain_timeout", sz, 0);
    cycle(1'b0, 8'h00, 3'b000, a);
    chk("vld_after_drain", vld_chan, 3'b000);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld"}, vld_chan, 3'b000);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_susp"}, suspend_data_in, 1'b0);
    chk({tag, "_data"}, channel_data, 24'h0);
  endtask

  initial begin
    logic [7:0] q[$];
    bit a;

    reset = 1'b1; packet_valid = 1'b0; data = '0; read_enb = '0;
    model_clear();
    #2;
    check_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: good packet to ch1, then read it back
    q = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h15};
    send_pkt(q);
    chk("t1_vld", vld_chan, 3'b010);
    for (int k = 0; k < 6; k++) begin
      chk("t1_read", channel_data[15:8], q[k]);
      cycle(1'b0, 8'h00, 3'b010, a);
    end
    chk("t1_empty", vld_chan, 3'b000);

    // 2: bad parity is stored and flagged
    q = '{8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h16};
    send_pkt(q);
    chk("t2_err_pulse", err, 1'b1);
    cycle(1'b0, 8'h00, 3'b000, a);
    chk("t2_err_one_cycle", err, 1'b0);
    drain();

    // 3: illegal address dropped, next packet routed to ch0
    q = '{8'h0B, 8'hAA, 8'h55, 8'h3C, 8'h00, 8'h00};
    send_pkt(q);
    chk("t3_vld", vld_chan, 3'b001);
    drain();

    // 4: fill ch2, sender held, one pop releases the held byte
    make_pkt(2, 20, 0, q);
    for (int k = 0; k < 16; k++) send_byte(q[k]);
    chk("t4_full_susp", suspend_data_in, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, q[16], 3'b000, a);
      chk("t4_hold", a, 0);
    end
    cycle(1'b1, q[16], 3'b100, a);
    chk("t4_pop_susp", a, 0);
    chk("t4_released", suspend_data_in, 1'b0);
    cycle(1'b1, q[16], 3'b000, a);
    chk("t4_held_taken", a, 1);
    rd_mask = 3'b100;
    for (int k = 17; k < q.size(); k++) send_byte(q[k]);
    rd_mask = 3'b000;
    drain();

    // 5: push and pop together on ch0 at occupancy 5, across pointer wrap
    make_pkt(0, 38, 0, q);
    for (int k = 0; k < 5; k++) send_byte(q[k]);
    rd_mask = 3'b001;
    for (int k = 5; k < q.size(); k++) send_byte(q[k]);
    rd_mask = 3'b000;
    chk("t5_occupancy_vld", vld_chan, 3'b001);
    drain();

    // 6: reset mid-payload, then a fresh packet
    make_pkt(1, 6, 0, q);
    for (int k = 0; k < 3; k++) send_byte(q[k]);
    reset = 1'b1;
    #1;
    model_clear();
    check_reset_outputs("t6_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    q = '{8'h00, 8'h00};
    send_pkt(q);
    chk("t6_fresh_vld", vld_chan, 3'b001);
    drain();

    // Random traffic with gaps, random reads and occasional corrupt or illegal packets
    gap_pct = 20;
    rd_pct  = 40;
    for (int p = 0; p < 40; p++) begin
      make_pkt($urandom_range(3), $urandom_range(7), $urandom_range(3) == 0, q);
      send_pkt(q);
    end
    gap_pct = 0;
    rd_pct  = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
